// File: rtl/rr_mux_arbiter8.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_mux_arbiter8 : round-robin, hold-limited owner of the shared 8:1 mux select
// Revision 1.0
// ---------------------------------------------------------------------------
module rr_mux_arbiter8 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       ARB_EN,
  input  logic [7:0] REQ,
  output logic [7:0] GNT,
  output logic [2:0] SEL,
  output logic       BUSY,
  output logic       PREEMPT
);

  localparam logic [CNT_W-1:0] c_max_hold = CNT_W'(MAX_HOLD);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_ptr, w_ptr_nxt;
  logic [2:0]       r_owner, w_owner_nxt;
  logic [2:0]       r_sel, w_sel_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [7:0]       r_gnt, w_gnt_nxt;
  logic             r_preempt, w_preempt_nxt;

  logic [15:0]      w_shift;
  logic [7:0]       w_rot;
  logic [2:0]       w_off;
  logic [2:0]       w_winner;
  logic [7:0]       w_others;

  // Rotate so that index r_ptr lands at bit 0; the lowest set bit is then the winner.
  assign w_shift  = {REQ, REQ} >> r_ptr;
  assign w_rot    = w_shift[7:0];
  assign w_winner = r_ptr + w_off;
  assign w_others = REQ & ~(8'd1 << r_owner);

  always_comb begin
    w_off = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_rot[i]) w_off = 3'(i);
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_owner_nxt   = r_owner;
    w_cnt_nxt     = r_cnt;
    w_gnt_nxt     = r_gnt;
    w_sel_nxt     = r_sel;
    w_preempt_nxt = 1'b0;
    case (r_state)
      S_IDLE, S_GAP: begin
        w_gnt_nxt = 8'd0;
        if (ARB_EN && (|REQ)) begin
          w_state_nxt = S_GRANT;
          w_owner_nxt = w_winner;
          w_gnt_nxt   = 8'd1 << w_winner;
          w_sel_nxt   = w_winner;
          w_cnt_nxt   = CNT_W'(1);
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_GRANT: begin
        if (!REQ[r_owner]) begin
          w_state_nxt = S_GAP;
          w_gnt_nxt   = 8'd0;
          w_ptr_nxt   = r_owner + 3'd1;
        end else if ((r_cnt == c_max_hold) && (|w_others)) begin
          w_state_nxt   = S_GAP;
          w_gnt_nxt     = 8'd0;
          w_ptr_nxt     = r_owner + 3'd1;
          w_preempt_nxt = 1'b1;
        end else if (r_cnt != c_max_hold) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= S_IDLE;
      r_ptr     <= 3'd0;
      r_owner   <= 3'd0;
      r_cnt     <= '0;
      r_gnt     <= 8'd0;
      r_sel     <= 3'd0;
      r_preempt <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_owner   <= w_owner_nxt;
      r_cnt     <= w_cnt_nxt;
      r_gnt     <= w_gnt_nxt;
      r_sel     <= w_sel_nxt;
      r_preempt <= w_preempt_nxt;
    end
  end

  assign GNT     = r_gnt;
  assign SEL     = r_sel;
  assign BUSY    = (r_state == S_GRANT);
  assign PREEMPT = r_preempt;

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_arbiter8.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rr_mux_arbiter8 : directed stimulus with a per-cycle expected-output queue
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_rr_mux_arbiter8;

  logic       CLK;
  logic       RST_N;
  logic       ARB_EN;
  logic [7:0] REQ;
  logic [7:0] GNT;
  logic [2:0] SEL;
  logic       BUSY;
  logic       PREEMPT;

  rr_mux_arbiter8 #(.MAX_HOLD(16), .CNT_W(5)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .ARB_EN  (ARB_EN),
    .REQ     (REQ),
    .GNT     (GNT),
    .SEL     (SEL),
    .BUSY    (BUSY),
    .PREEMPT (PREEMPT)
  );

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       pre;
    int         id;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_step  = 0;
  logic [2:0] o;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp_v);
    end
  endtask

  // Drive one cycle of inputs and queue what the outputs must be after the next edge.
  task automatic step(input logic [7:0] req, input logic en, input logic [7:0] g,
                      input logic [2:0] s, input logic b, input logic p);
    @(negedge CLK);
    REQ    = req;
    ARB_EN = en;
    sb.push_back('{g, s, b, p, n_step});
    n_step++;
  endtask

  always @(posedge CLK) begin
    #1;
    if (sb.size() > 0) begin
      e_mon = sb.pop_front();
      n_tests++;
      if ({GNT, SEL, BUSY, PREEMPT} !== {e_mon.gnt, e_mon.sel, e_mon.busy, e_mon.pre}) begin
        n_fail++;
        $display("FAIL step%0d: got gnt=%h sel=%0d busy=%b preempt=%b, required gnt=%h sel=%0d busy=%b preempt=%b",
                 e_mon.id, GNT, SEL, BUSY, PREEMPT, e_mon.gnt, e_mon.sel, e_mon.busy, e_mon.pre);
      end
      n_tests++;
      if ((GNT != 8'd0) && (!BUSY || (GNT != (8'd1 << SEL)))) begin
        n_fail++;
        $display("FAIL invariant step%0d: got gnt=%h sel=%0d busy=%b, required one-hot gnt matching sel with busy",
                 e_mon.id, GNT, SEL, BUSY);
      end
    end
  end

  initial begin
    RST_N  = 1'b1;
    ARB_EN = 1'b1;
    REQ    = 8'h00;
    #1 RST_N = 1'b0;
    #2;
    check("reset_outputs", {20'd0, GNT, SEL, BUSY, PREEMPT}, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    // Full contention from PTR=0: 0..7 then 0 again, 16 cycles each, preempt, one gap.
    for (int g = 0; g < 9; g++) begin
      o = 3'(g % 8);
      repeat (16) step(8'hFF, 1'b1, 8'd1 << o, o, 1'b1, 1'b0);
      step(8'hFF, 1'b1, 8'h00, o, 1'b0, 1'b1);
    end
    step(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);

    // Single request held three cycles.
    repeat (3) step(8'h08, 1'b1, 8'h08, 3'd3, 1'b1, 1'b0);
    step(8'h00, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0);
    step(8'h00, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0);

    // Pointer wrap: grant 6, release, then 0x41 must go to 0 before 6.
    step(8'h40, 1'b1, 8'h40, 3'd6, 1'b1, 1'b0);
    step(8'h00, 1'b1, 8'h00, 3'd6, 1'b0, 1'b0);
    step(8'h00, 1'b1, 8'h00, 3'd6, 1'b0, 1'b0);
    step(8'h41, 1'b1, 8'h01, 3'd0, 1'b1, 1'b0);
    step(8'h40, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
    step(8'h40, 1'b1, 8'h40, 3'd6, 1'b1, 1'b0);
    step(8'h00, 1'b1, 8'h00, 3'd6, 1'b0, 1'b0);
    step(8'h00, 1'b1, 8'h00, 3'd6, 1'b0, 1'b0);

    // ARB_EN gating: grant to 5 survives ARB_EN low, no regrant until re-enabled.
    step(8'h20, 1'b1, 8'h20, 3'd5, 1'b1, 1'b0);
    repeat (3) step(8'h21, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0);
    step(8'h01, 1'b0, 8'h00, 3'd5, 1'b0, 1'b0);
    repeat (2) step(8'h01, 1'b0, 8'h00, 3'd5, 1'b0, 1'b0);
    step(8'h01, 1'b1, 8'h01, 3'd0, 1'b1, 1'b0);
    step(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
    step(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);

    // Sole requester keeps the path past the hold limit, then yields to requester 2.
    repeat (40) step(8'h10, 1'b1, 8'h10, 3'd4, 1'b1, 1'b0);
    @(negedge CLK);
    check("cnt_saturated", 32'(dut.r_cnt), 32'd16);
    REQ = 8'h10;
    sb.push_back('{8'h10, 3'd4, 1'b1, 1'b0, n_step});
    n_step++;
    step(8'h14, 1'b1, 8'h00, 3'd4, 1'b0, 1'b1);
    step(8'h14, 1'b1, 8'h04, 3'd2, 1'b1, 1'b0);
    step(8'h00, 1'b1, 8'h00, 3'd2, 1'b0, 1'b0);
    step(8'h00, 1'b1, 8'h00, 3'd2, 1'b0, 1'b0);

    // Reset mid-grant, then arbitration restarts from PTR=0.
    step(8'h04, 1'b1, 8'h04, 3'd2, 1'b1, 1'b0);
    step(8'h04, 1'b1, 8'h04, 3'd2, 1'b1, 1'b0);
    @(negedge CLK);
    #2 RST_N = 1'b0;
    REQ = 8'h06;
    #1;
    check("reset_mid_grant", {20'd0, GNT, SEL, BUSY, PREEMPT}, 32'd0);
    #1 RST_N = 1'b1;
    sb.push_back('{8'h02, 3'd1, 1'b1, 1'b0, n_step});
    n_step++;
    step(8'h06, 1'b1, 8'h02, 3'd1, 1'b1, 1'b0);
    step(8'h04, 1'b1, 8'h00, 3'd1, 1'b0, 1'b0);
    step(8'h04, 1'b1, 8'h04, 3'd2, 1'b1, 1'b0);
    step(8'h00, 1'b1, 8'h00, 3'd2, 1'b0, 1'b0);
    step(8'h00, 1'b1, 8'h00, 3'd2, 1'b0, 1'b0);

    @(negedge CLK);
    @(negedge CLK);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
